song_sequencer: RTL and testbench

//  Playback controller for the square-wave tone generator. Walks a note ROM holding several songs
//  and presents each note's 15-bit preset (tone_origin) and enable to the generator.

---
 rtl/song_sequencer_pkg.sv | 37 +++
 rtl/song_sequencer_beat.sv | 29 ++
 rtl/song_sequencer.sv | 167 ++++++++++++++++
 tb/tb_song_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared types and ROM word layout for the song sequencer.
// Note presets are tone-divider reload values for the square-wave generator.
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_NOTE,
    S_GAP,
    S_PAUSED
  } state_t;

  localparam int END_BIT    = 19;
  localparam int BEATS_MSB  = 18;
  localparam int BEATS_LSB  = 15;
  localparam int PRESET_MSB = 14;
  localparam int PRESET_LSB = 0;

  localparam logic [14:0] REST      = 15'h0000;
  localparam logic [14:0] ALTO_DO   = 15'h625F;
  localparam logic [14:0] ALTO_RE   = 15'h6715;
  localparam logic [14:0] ALTO_MI   = 15'h6B1D;
  localparam logic [14:0] ALTO_FA   = 15'h6D10;
  localparam logic [14:0] ALTO_SO   = 15'h709B;
  localparam logic [14:0] TREBLE_DO = 15'h7130;
  localparam logic [14:0] TREBLE_RE = 15'h738A;

  function automatic logic [19:0] mk_note(
    input logic        last,
    input logic [3:0]  beats,
    input logic [14:0] preset
  );
    return {last, beats, preset};
  endfunction

endpackage

// File: rtl/song_sequencer_beat.sv
// Free-running divide-by-DIV counter with clear and enable.
// tick is high in the enabled cycle where the count sits at DIV-1.
module beat_timer #(
  parameter int DIV = 10
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Note-ROM playback controller feeding the square-wave tone divider.
// Handles play/pause, stop and next-song buttons with beat-timed notes.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BEAT_HZ = 5,
  parameter int GAP_CYC = 500_000,
  parameter int SONGS   = 4,
  parameter int ADDR_W  = 8,
  localparam int SONG_W = $clog2(SONGS)
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic                     btn_play,
  input  logic                     btn_stop,
  input  logic                     btn_next,
  output logic [SONG_W+ADDR_W-1:0] rom_addr,
  input  logic [19:0]              rom_data,
  output logic [14:0]              tone_origin,
  output logic                     tone_en,
  output logic [SONG_W-1:0]        song_idx,
  output logic                     playing,
  output logic                     beat_tick
);

  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;

  state_t              state;
  state_t              saved;
  logic [ADDR_W-1:0]   note_idx;
  logic [3:0]          beats_left;
  logic                b_tick;
  logic                g_tick;
  logic                b_clr;
  logic                b_en;
  logic                g_clr;
  logic                g_en;
  logic                last_beat;
  logic [SONG_W-1:0]   song_nx;
  logic [ADDR_W-1:0]   note_nx;
  logic [3:0]          beats_in;
  logic [14:0]         preset_in;

  assign song_nx   = song_idx + SONG_W'(1);
  assign note_nx   = note_idx + ADDR_W'(1);
  assign beats_in  = rom_data[BEATS_MSB:BEATS_LSB];
  assign preset_in = rom_data[PRESET_MSB:PRESET_LSB];
  assign last_beat = b_tick && (beats_left == 4'd1);

  // Gap timer is held clear throughout NOTE so GAP always starts at zero.
  assign b_clr = (state == S_LOAD);
  assign b_en  = (state == S_NOTE);
  assign g_clr = (state == S_NOTE);
  assign g_en  = (state == S_GAP);

  beat_timer #(.DIV(BEAT_DIV)) u_beat (
    .clk_50M (clk_50M),
    .rst     (rst),
    .clr     (b_clr),
    .en      (b_en),
    .tick    (b_tick)
  );

  beat_timer #(.DIV(GAP_CYC)) u_gap (
    .clk_50M (clk_50M),
    .rst     (rst),
    .clr     (g_clr),
    .en      (g_en),
    .tick    (g_tick)
  );

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      saved       <= S_IDLE;
      note_idx    <= '0;
      beats_left  <= 4'd0;
      rom_addr    <= '0;
      tone_origin <= '0;
      tone_en     <= 1'b0;
      song_idx    <= '0;
      playing     <= 1'b0;
      beat_tick   <= 1'b0;
    end else begin
      beat_tick <= b_tick;
      if (btn_stop) begin
        state    <= S_IDLE;
        note_idx <= '0;
        tone_en  <= 1'b0;
        playing  <= 1'b0;
      end else if (btn_next) begin
        song_idx <= song_nx;
        if (state != S_IDLE) begin
          state    <= S_FETCH;
          note_idx <= '0;
          rom_addr <= {song_nx, {ADDR_W{1'b0}}};
          tone_en  <= 1'b0;
          playing  <= 1'b1;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (btn_play) begin
              state    <= S_FETCH;
              note_idx <= '0;
              rom_addr <= {song_idx, {ADDR_W{1'b0}}};
              playing  <= 1'b1;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            if (rom_data[END_BIT]) begin
              state    <= S_IDLE;
              note_idx <= '0;
              playing  <= 1'b0;
            end else begin
              tone_origin <= preset_in;
              beats_left  <= (beats_in == 4'd0) ? 4'd1 : beats_in;
              tone_en     <= (preset_in != REST);
              state       <= S_NOTE;
            end
          end
          S_NOTE: begin
            if (b_tick && !last_beat) beats_left <= beats_left - 4'd1;
            // The pause cycle itself is counted, so resume continues seamlessly.
            if (btn_play) begin
              state   <= S_PAUSED;
              saved   <= last_beat ? S_GAP : S_NOTE;
              tone_en <= 1'b0;
              playing <= 1'b0;
            end else if (last_beat) begin
              state   <= S_GAP;
              tone_en <= 1'b0;
            end
          end
          S_GAP: begin
            if (g_tick) begin
              if (&note_idx) begin
                state    <= S_IDLE;
                note_idx <= '0;
                playing  <= 1'b0;
              end else begin
                state    <= S_FETCH;
                note_idx <= note_nx;
                rom_addr <= {song_idx, note_nx};
              end
            end else if (btn_play) begin
              state   <= S_PAUSED;
              saved   <= S_GAP;
              playing <= 1'b0;
            end
          end
          S_PAUSED: begin
            if (btn_play) begin
              state   <= saved;
              playing <= 1'b1;
              tone_en <= (saved == S_NOTE) && (tone_origin != REST);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small two-song ROM.
// Cycle numbers are counted from the cycle a button pulse is driven.
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        btn_play = 1'b0;
  logic        btn_stop = 1'b0;
  logic        btn_next = 1'b0;
  logic [3:0]  rom_addr;
  logic [19:0] rom_data = '0;
  logic [14:0] tone_origin;
  logic        tone_en;
  logic [0:0]  song_idx;
  logic        playing;
  logic        beat_tick;

  logic [19:0] rom [0:15];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk_50M = ~clk_50M;

  always @(posedge clk_50M) rom_data <= rom[rom_addr];

  song_sequencer #(
    .CLK_HZ  (100),
    .BEAT_HZ (10),
    .GAP_CYC (2),
    .SONGS   (2),
    .ADDR_W  (3)
  ) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .btn_play    (btn_play),
    .btn_stop    (btn_stop),
    .btn_next    (btn_next),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .tone_origin (tone_origin),
    .tone_en     (tone_en),
    .song_idx    (song_idx),
    .playing     (playing),
    .beat_tick   (beat_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
    cyc++;
  endtask

  task automatic pulse(input logic p, input logic s, input logic n);
    btn_play = p;
    btn_stop = s;
    btn_next = n;
    step();
    btn_play = 1'b0;
    btn_stop = 1'b0;
    btn_next = 1'b0;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = mk_note(1'b1, 4'd0, REST);
    rom[0]  = mk_note(1'b0, 4'd2, ALTO_DO);
    rom[1]  = mk_note(1'b0, 4'd1, ALTO_RE);
    rom[8]  = mk_note(1'b0, 4'd1, ALTO_MI);
    rom[9]  = mk_note(1'b0, 4'd1, ALTO_FA);
    rom[10] = mk_note(1'b0, 4'd1, REST);
    rom[11] = mk_note(1'b0, 4'd1, ALTO_SO);
    rom[12] = mk_note(1'b0, 4'd1, TREBLE_DO);
    rom[13] = mk_note(1'b0, 4'd0, TREBLE_RE);
    rom[14] = mk_note(1'b0, 4'd1, ALTO_DO);
    rom[15] = mk_note(1'b0, 4'd1, ALTO_RE);

    // reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_addr", rom_addr, 0);
    chk("rst_origin", tone_origin, 0);
    chk("rst_en", tone_en, 0);
    chk("rst_song", song_idx, 0);
    chk("rst_play", playing, 0);
    chk("rst_tick", beat_tick, 0);
    rst = 1'b0;
    step();

    // song 0: 2-beat DO, 1-beat RE, END
    cyc = 0;
    pulse(1'b1, 1'b0, 1'b0);
    chk("s0_fetch_play", playing, 1);
    chk("s0_fetch_addr", rom_addr, 0);
    chk("s0_fetch_en", tone_en, 0);
    go(2);
    chk("s0_load_en", tone_en, 0);
    go(3);
    for (int i = 0; i < 20; i++) begin
      chk("s0_n0_en", tone_en, 1);
      chk("s0_n0_origin", tone_origin, 15'h625F);
      chk("s0_n0_tick", beat_tick, (i == 10) ? 1 : 0);
      step();
    end
    chk("s0_gap_en", tone_en, 0);
    chk("s0_gap_tick", beat_tick, 1);
    go(24);
    chk("s0_gap2_en", tone_en, 0);
    go(25);
    chk("s0_n1_addr", rom_addr, 1);
    chk("s0_n1_fetch_en", tone_en, 0);
    go(27);
    chk("s0_n1_en", tone_en, 1);
    chk("s0_n1_origin", tone_origin, 15'h6715);
    go(36);
    chk("s0_n1_last_en", tone_en, 1);
    go(37);
    chk("s0_n1_gap_en", tone_en, 0);
    go(39);
    chk("s0_end_addr", rom_addr, 2);
    chk("s0_end_play", playing, 1);
    go(41);
    chk("s0_idle_play", playing, 0);
    chk("s0_idle_en", tone_en, 0);
    chk("s0_idle_origin", tone_origin, 15'h6715);

    // pause at beat count 7 for 50 cycles
    cyc = 0;
    pulse(1'b1, 1'b0, 1'b0);
    go(10);
    chk("pz_before_en", tone_en, 1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("pz_en", tone_en, 0);
    chk("pz_play", playing, 0);
    go(60);
    chk("pz_hold_en", tone_en, 0);
    chk("pz_hold_tick", beat_tick, 0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("pz_res_en", tone_en, 1);
    chk("pz_res_play", playing, 1);
    chk("pz_res_tick1", beat_tick, 0);
    step();
    chk("pz_res_tick2", beat_tick, 0);
    step();
    chk("pz_res_tick3", beat_tick, 1);
    go(72);
    chk("pz_n0_end_en", tone_en, 1);
    go(73);
    chk("pz_gap_en", tone_en, 0);
    go(75);
    chk("pz_n1_addr", rom_addr, 1);
    go(77);
    chk("pz_n1_origin", tone_origin, 15'h6715);

    // stop + next + play together during note 1
    go(80);
    pulse(1'b1, 1'b1, 1'b1);
    chk("stp_play", playing, 0);
    chk("stp_en", tone_en, 0);
    chk("stp_song", song_idx, 0);
    chk("stp_addr_hold", rom_addr, 1);
    cyc = 0;
    pulse(1'b1, 1'b0, 1'b0);
    chk("stp_replay_addr", rom_addr, 0);

    // next during NOTE of song 0 jumps to song 1
    go(5);
    pulse(1'b0, 1'b0, 1'b1);
    chk("nx_song", song_idx, 1);
    chk("nx_addr", rom_addr, 8);
    chk("nx_play", playing, 1);
    chk("nx_en", tone_en, 0);
    go(8);
    chk("s1_n0_en", tone_en, 1);
    chk("s1_n0_origin", tone_origin, 15'h6B1D);
    go(36);
    chk("s1_rest_en", tone_en, 0);
    chk("s1_rest_origin", tone_origin, 0);
    chk("s1_rest_play", playing, 1);
    go(45);
    chk("s1_rest_end_en", tone_en, 0);
    go(50);
    chk("s1_n3_en", tone_en, 1);
    chk("s1_n3_origin", tone_origin, 15'h709B);
    go(78);
    chk("s1_n5_en", tone_en, 1);
    chk("s1_n5_origin", tone_origin, 15'h738A);
    go(87);
    chk("s1_n5_last_en", tone_en, 1);
    go(88);
    chk("s1_n5_gap_en", tone_en, 0);
    go(115);
    chk("s1_n7_en", tone_en, 1);
    chk("s1_n7_origin", tone_origin, 15'h6715);
    go(117);
    chk("s1_last_gap_play", playing, 1);
    chk("s1_last_gap_en", tone_en, 0);
    go(118);
    chk("s1_idle_play", playing, 0);
    chk("s1_idle_addr", rom_addr, 15);

    // next in IDLE only changes the selection, with wrap
    pulse(1'b0, 1'b0, 1'b1);
    chk("idl_nx_song", song_idx, 0);
    chk("idl_nx_play", playing, 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("idl_nx2_song", song_idx, 1);

    // reset in the middle of a note
    cyc = 0;
    pulse(1'b1, 1'b0, 1'b0);
    go(5);
    chk("mr_en", tone_en, 1);
    chk("mr_origin", tone_origin, 15'h6B1D);
    chk("mr_addr", rom_addr, 8);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_rst_addr", rom_addr, 0);
    chk("mr_rst_origin", tone_origin, 0);
    chk("mr_rst_en", tone_en, 0);
    chk("mr_rst_song", song_idx, 0);
    chk("mr_rst_play", playing, 0);
    chk("mr_rst_tick", beat_tick, 0);
    rst = 1'b0;
    step();
    chk("mr_after_play", playing, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
